// File: rtl/bcd_display_ctrl.sv
// Iterative double-dabble binary-to-BCD converter with atomic digit publish.
// Define BCD_CTRL_LEAD_BLANK_EN to blank leading zero digits with 4'hF.
module bcd_display_ctrl #(
    parameter int DISPLAYS_NUM = 4,
    parameter int BIN_WIDTH    = 14
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [BIN_WIDTH-1:0]      i_bin,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [DISPLAYS_NUM*4-1:0] o_bcd_data,
    output logic                      o_update,
    output logic                      o_overflow
);

    localparam int DW = DISPLAYS_NUM * 4;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] calc_max();
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < DISPLAYS_NUM; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = calc_max();
    localparam logic [BIN_WIDTH-1:0] MAX_BIN = MAX_VAL[BIN_WIDTH-1:0];

`ifdef BCD_CTRL_LEAD_BLANK_EN
    // Leading zeros above digit 0 become the blank code.
    function automatic logic [DW-1:0] lead_blank(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic          lead;
        r    = d;
        lead = 1'b1;
        for (int i = DISPLAYS_NUM - 1; i > 0; i--) begin
            if (lead && d[i*4+:4] == 4'd0) begin
                r[i*4+:4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD
    } state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          digits_q, digits_d;
    logic [BIN_WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [DW-1:0]          bcd_q, bcd_d;
    logic                   update_q, update_d;
    logic                   overflow_q, overflow_d;
    logic [DW-1:0]          adj;
    logic                   too_big;

    assign o_ready    = (state_q == S_IDLE) && i_rst;
    assign o_bcd_data = bcd_q;
    assign o_update   = update_q;
    assign o_overflow = overflow_q;

    assign too_big = {{(64-BIN_WIDTH){1'b0}}, i_bin} > MAX_VAL;

    // Add-3 correction for every digit at or above five.
    always_comb begin
        adj = digits_q;
        for (int i = 0; i < DISPLAYS_NUM; i++) begin
            if (digits_q[i*4+:4] >= 4'd5) begin
                adj[i*4+:4] = digits_q[i*4+:4] + 4'd3;
            end
        end
    end

    // Next-state and datapath updates for the converter FSM.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        update_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid && o_ready) begin
                    shift_d  = too_big ? MAX_BIN : i_bin;
                    ovf_d    = too_big;
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                digits_d = {adj[DW-2:0], shift_q[BIN_WIDTH-1]};
                shift_d  = shift_q << 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_WIDTH - 1)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef BCD_CTRL_LEAD_BLANK_EN
                bcd_d = lead_blank(digits_q);
`else
                bcd_d = digits_q;
`endif
                overflow_d = ovf_q;
                update_d   = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            digits_q   <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            update_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            update_q   <= update_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
